// File: rtl/regfile_dump.sv
// Debug read-out engine: sweeps register indices FIRST..LAST on a spare read port
// and streams each captured (index, data) pair over a valid/ready handshake.
module regfile_dump #(
    parameter int FIRST = 0,
    parameter int LAST  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [63:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST);
    localparam logic [4:0] LAST_IDX  = 5'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_idx_q, out_idx_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d = rd;
                out_idx_d  = idx_q;
                out_last_d = (idx_q == LAST_IDX);
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered by decoding the next state.
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d == LOAD) || (state_d == SEND);
        done_d      = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 5'd0;
            out_data_q  <= 64'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ra        = idx_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
